// File: rtl/axi4s_prbs_monitor_if.sv
// AXI4-Stream error-pattern link from the PRBS checker into the monitor.
interface axi4s_prbs_monitor_if #(
  parameter int TDATA_WIDTH = 8
) ();
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;

  modport master (output tvalid, output tdata, output tlast, input  tready);
  modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

// File: rtl/axi4s_prbs_monitor.sv
// PRBS error-pattern sink: popcount stage, SEARCH/LOCKED lock FSM and
// saturating BER statistics for register readout.
module axi4s_prbs_monitor #(
  parameter int TDATA_WIDTH     = 8,
  parameter int CNT_WIDTH       = 32,
  parameter int LOCK_BEATS      = 16,
  parameter int LOSS_BEATS      = 4,
  parameter int BEAT_ERR_THRESH = 2
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi4s_prbs_monitor_if.slave  target,
  input  logic                 clear,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic [CNT_WIDTH-1:0] bit_err_count,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] pkt_err_count,
  output logic [CNT_WIDTH-1:0] lock_loss_count
);
  localparam int PCW = $clog2(TDATA_WIDTH + 1);
  localparam int CLW = $clog2(LOCK_BEATS + 1);
  localparam int BLW = $clog2(LOSS_BEATS + 1);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]     state;
  logic           ready_q;
  logic           s1_vld;
  logic [PCW-1:0] s1_pc;
  logic           s1_last;
  logic [PCW-1:0] pc;
  logic [CLW-1:0] clean_run;
  logic [BLW-1:0] bad_run;
  logic           pkt_err;
  logic           beat_bad;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Sum is one bit wider than the counter so overflow is visible before clamping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [PCW-1:0]       p);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + (CNT_WIDTH+1)'(p);
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    pc = '0;
    for (int i = 0; i < TDATA_WIDTH; i++) pc = pc + PCW'(target.tdata[i]);
  end

  assign target.tready = ready_q;
  assign locked        = (state == LOCKED);
  assign beat_bad      = int'(s1_pc) > BEAT_ERR_THRESH;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state           <= SEARCH;
      ready_q         <= 1'b0;
      s1_vld          <= 1'b0;
      s1_pc           <= '0;
      s1_last         <= 1'b0;
      clean_run       <= '0;
      bad_run         <= '0;
      pkt_err         <= 1'b0;
      beat_count      <= '0;
      bit_err_count   <= '0;
      pkt_count       <= '0;
      pkt_err_count   <= '0;
      lock_loss_count <= '0;
    end else begin
      ready_q <= 1'b1;
      s1_vld  <= target.tvalid & ready_q;
      if (target.tvalid & ready_q) begin
        s1_pc   <= pc;
        s1_last <= target.tlast;
      end

      if (s1_vld) begin
        if (state == SEARCH) begin
          if (s1_pc == '0) begin
            if (clean_run == CLW'(LOCK_BEATS - 1)) begin
              state     <= LOCKED;
              clean_run <= '0;
              bad_run   <= '0;
              pkt_err   <= 1'b0;
            end else begin
              clean_run <= clean_run + 1'b1;
            end
          end else begin
            clean_run <= '0;
          end
        end else begin
          beat_count    <= sat_inc(beat_count);
          bit_err_count <= sat_add(bit_err_count, s1_pc);
          if (s1_last) begin
            pkt_count <= sat_inc(pkt_count);
            if (pkt_err || s1_pc != '0) pkt_err_count <= sat_inc(pkt_err_count);
            pkt_err <= 1'b0;
          end else if (s1_pc != '0) begin
            pkt_err <= 1'b1;
          end
          // Losing beat is still counted above; a partial packet is simply dropped.
          if (beat_bad) begin
            if (bad_run == BLW'(LOSS_BEATS - 1)) begin
              state           <= SEARCH;
              lock_loss_count <= sat_inc(lock_loss_count);
              bad_run         <= '0;
              clean_run       <= '0;
              pkt_err         <= 1'b0;
            end else begin
              bad_run <= bad_run + 1'b1;
            end
          end else begin
            bad_run <= '0;
          end
        end
      end

      // Later assignment wins: clear drops this cycle's statistics update.
      if (clear) begin
        beat_count      <= '0;
        bit_err_count   <= '0;
        pkt_count       <= '0;
        pkt_err_count   <= '0;
        lock_loss_count <= '0;
      end
    end
  end
endmodule
